// File: rtl/idma_desc64_ar_prefetcher.sv
// Descriptor AR prefetcher for the desc64 frontend: speculatively reads the chain at +32 strides
// and tells the R-channel gater how many speculative bursts to drop when the guess goes wrong.
module idma_desc64_ar_prefetcher #(
   parameter int unsigned AddrWidth     = 64,
   parameter int unsigned PrefetchDepth = 4,
   parameter int unsigned FlushWidth    = $clog2(PrefetchDepth + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [AddrWidth-1:0]  head_addr_i,
   input  logic                  head_valid_i,
   output logic                  head_ready_o,
   output logic [AddrWidth-1:0]  ar_addr_o,
   output logic [7:0]            ar_len_o,
   output logic [2:0]            ar_size_o,
   output logic [1:0]            ar_burst_o,
   output logic                  ar_valid_o,
   input  logic                  ar_ready_i,
   input  logic                  desc_done_i,
   input  logic [AddrWidth-1:0]  desc_next_i,
   output logic [FlushWidth-1:0] n_to_flush_o,
   output logic                  n_to_flush_valid_o,
   output logic                  busy_o
);

   // At least two slots so that "entry 1" always names a real register.
   localparam int unsigned Slots = (PrefetchDepth < 2) ? 2 : PrefetchDepth;
   localparam logic [AddrWidth-1:0] DescBytes = AddrWidth'(32);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t                 state_reg;
   logic [AddrWidth-1:0]   fifo_reg  [Slots];
   logic [AddrWidth-1:0]   fifo_next [Slots];
   logic [FlushWidth-1:0]  occ_reg;
   logic [AddrWidth-1:0]   next_addr_reg;
   logic                   pend_discard_reg;
   logic                   ar_valid_reg;
   logic [AddrWidth-1:0]   ar_addr_reg;
   logic                   flush_valid_reg;
   logic [FlushWidth-1:0]  flush_cnt_reg;
   logic                   head_ready_reg;
   logic                   busy_reg;

   logic                   ar_hs;
   logic                   done;
   logic                   push;
   logic                   is_end;
   logic                   flush;
   logic                   ar_counted;
   logic                   room;
   logic [AddrWidth-1:0]   expected_addr;
   logic [FlushWidth-1:0]  flush_cnt;
   logic [FlushWidth-1:0]  occ_after_pop;
   logic [FlushWidth-1:0]  occ_next;

   assign ar_hs         = ar_valid_reg & ar_ready_i;
   assign done          = desc_done_i && (state_reg == FETCH) && (occ_reg != '0);
   assign ar_counted    = ar_valid_reg && !pend_discard_reg;
   assign is_end        = &desc_next_i;

   // The descriptor after the one just decoded is whatever we would have fetched next.
   always_comb begin
      expected_addr = next_addr_reg;
      if (32'(occ_reg) >= 32'd2) begin
         expected_addr = fifo_reg[1];
      end else if (ar_counted) begin
         expected_addr = ar_addr_reg;
      end
   end

   assign flush         = done && (is_end || (desc_next_i != expected_addr));
   assign flush_cnt     = occ_reg - FlushWidth'(1) + FlushWidth'(ar_counted);
   assign push          = ar_hs && !pend_discard_reg && !flush && (state_reg == FETCH);
   assign occ_after_pop = occ_reg - FlushWidth'(done);
   assign occ_next      = flush ? '0 : occ_after_pop + FlushWidth'(push);
   assign room          = 32'(occ_next) < PrefetchDepth;

   // Shift-register FIFO: slot 0 is the oldest outstanding descriptor.
   for (genvar gi = 0; gi < Slots; gi++) begin : g_fifo
      logic [AddrWidth-1:0] shifted;
      if (gi + 1 < Slots) begin : g_shift
         assign shifted = done ? fifo_reg[gi+1] : fifo_reg[gi];
      end else begin : g_last
         assign shifted = fifo_reg[gi];
      end
      assign fifo_next[gi] = (push && (occ_after_pop == FlushWidth'(gi))) ? ar_addr_reg : shifted;
   end

   always_ff @(posedge clk_i) begin
      fifo_reg <= fifo_next;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg        <= IDLE;
         occ_reg          <= '0;
         next_addr_reg    <= '0;
         pend_discard_reg <= 1'b0;
         ar_valid_reg     <= 1'b0;
         ar_addr_reg      <= '0;
         flush_valid_reg  <= 1'b0;
         flush_cnt_reg    <= '0;
         head_ready_reg   <= 1'b1;
         busy_reg         <= 1'b0;
      end else begin
         flush_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (head_valid_i) begin
                  next_addr_reg    <= head_addr_i;
                  occ_reg          <= '0;
                  pend_discard_reg <= 1'b0;
                  state_reg        <= FETCH;
                  head_ready_reg   <= 1'b0;
                  busy_reg         <= 1'b1;
               end
            end
            FETCH: begin
               occ_reg <= occ_next;
               if (flush) begin
                  flush_cnt_reg    <= flush_cnt;
                  flush_valid_reg  <= (flush_cnt != '0);
                  // A still-presented AR must stay stable but its data is already written off.
                  pend_discard_reg <= ar_valid_reg && !ar_hs;
                  if (ar_hs) begin
                     ar_valid_reg <= 1'b0;
                  end
                  if (is_end) begin
                     if (ar_valid_reg && !ar_hs) begin
                        state_reg <= DRAIN;
                     end else begin
                        state_reg      <= IDLE;
                        head_ready_reg <= 1'b1;
                        busy_reg       <= 1'b0;
                     end
                  end else begin
                     next_addr_reg <= desc_next_i;
                  end
               end else begin
                  if (ar_hs) begin
                     pend_discard_reg <= 1'b0;
                  end
                  if (!ar_valid_reg || ar_hs) begin
                     if (room) begin
                        ar_valid_reg  <= 1'b1;
                        ar_addr_reg   <= next_addr_reg;
                        next_addr_reg <= next_addr_reg + DescBytes;
                     end else begin
                        ar_valid_reg <= 1'b0;
                     end
                  end
               end
            end
            DRAIN: begin
               if (!ar_valid_reg || ar_hs) begin
                  ar_valid_reg     <= 1'b0;
                  pend_discard_reg <= 1'b0;
                  state_reg        <= IDLE;
                  head_ready_reg   <= 1'b1;
                  busy_reg         <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign head_ready_o       = head_ready_reg;
   assign busy_o             = busy_reg;
   assign ar_addr_o          = ar_addr_reg;
   assign ar_valid_o         = ar_valid_reg;
   assign ar_len_o           = 8'd3;
   assign ar_size_o          = 3'd3;
   assign ar_burst_o         = 2'b01;
   assign n_to_flush_o       = flush_cnt_reg;
   assign n_to_flush_valid_o = flush_valid_reg;

   ap_done_has_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
      desc_done_i |-> (occ_reg != '0));

endmodule

// File: tb/tb_idma_desc64_ar_prefetcher.sv
// Directed bench for idma_desc64_ar_prefetcher: chains, mispredicts, pending-AR discard,
// same-cycle handshake/decode, end of chain and asynchronous reset.
module tb_idma_desc64_ar_prefetcher;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [63:0] head_addr;
   logic        head_valid;
   logic        head_ready;
   logic [63:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic        ar_valid;
   logic        ar_ready;
   logic        desc_done;
   logic [63:0] desc_next;
   logic [2:0]  n_to_flush;
   logic        n_to_flush_valid;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   idma_desc64_ar_prefetcher dut (
      .clk_i              (clk),
      .rst_ni             (rst_ni),
      .head_addr_i        (head_addr),
      .head_valid_i       (head_valid),
      .head_ready_o       (head_ready),
      .ar_addr_o          (ar_addr),
      .ar_len_o           (ar_len),
      .ar_size_o          (ar_size),
      .ar_burst_o         (ar_burst),
      .ar_valid_o         (ar_valid),
      .ar_ready_i         (ar_ready),
      .desc_done_i        (desc_done),
      .desc_next_i        (desc_next),
      .n_to_flush_o       (n_to_flush),
      .n_to_flush_valid_o (n_to_flush_valid),
      .busy_o             (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ar(input string tag, input logic [63:0] addr);
      check({tag, "_valid"}, 64'(ar_valid), 64'd1);
      check({tag, "_addr"}, ar_addr, addr);
   endtask

   task automatic chk_idle(input string tag);
      check({tag, "_arvalid"}, 64'(ar_valid), 64'd0);
      check({tag, "_head_ready"}, 64'(head_ready), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic start_chain(input logic [63:0] addr);
      head_addr  = addr;
      head_valid = 1'b1;
      step();
      head_valid = 1'b0;
   endtask

   task automatic pulse_done(input logic [63:0] nxt);
      desc_done = 1'b1;
      desc_next = nxt;
      step();
      desc_done = 1'b0;
   endtask

   task automatic do_reset();
      rst_ni     = 1'b0;
      head_valid = 1'b0;
      desc_done  = 1'b0;
      ar_ready   = 1'b0;
      step();
      step();
      rst_ni = 1'b1;
   endtask

   initial begin
      rst_ni     = 1'b0;
      head_addr  = '0;
      head_valid = 1'b0;
      ar_ready   = 1'b0;
      desc_done  = 1'b0;
      desc_next  = '0;
      step();
      step();

      // Reset state and constant AR attributes
      check("rst_arvalid", 64'(ar_valid), 64'd0);
      check("rst_araddr", ar_addr, 64'd0);
      check("rst_fvalid", 64'(n_to_flush_valid), 64'd0);
      check("rst_nflush", 64'(n_to_flush), 64'd0);
      check("rst_head_ready", 64'(head_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      rst_ni = 1'b1;
      step();
      check("ar_len", 64'(ar_len), 64'd3);
      check("ar_size", 64'(ar_size), 64'd3);
      check("ar_burst", 64'(ar_burst), 64'd1);

      // Contiguous chain 0x1000: four ARs back to back, then depth-limited
      ar_ready = 1'b1;
      start_chain(64'h1000);
      check("c1_head_ready", 64'(head_ready), 64'd0);
      check("c1_busy", 64'(busy), 64'd1);
      check("c1_no_ar_yet", 64'(ar_valid), 64'd0);
      step();
      chk_ar("c1_ar0", 64'h1000);
      step();
      chk_ar("c1_ar1", 64'h1020);
      step();
      chk_ar("c1_ar2", 64'h1040);
      step();
      chk_ar("c1_ar3", 64'h1060);
      step();
      check("c1_full_stop", 64'(ar_valid), 64'd0);
      ar_ready = 1'b0;
      step();
      check("c1_full_hold", 64'(ar_valid), 64'd0);
      pulse_done(64'h1020);
      check("c1_done1_nostrobe", 64'(n_to_flush_valid), 64'd0);
      chk_ar("c1_refill", 64'h1080);
      pulse_done(64'h1040);
      check("c1_done2_nostrobe", 64'(n_to_flush_valid), 64'd0);
      pulse_done(ONES);
      check("c1_end_strobe", 64'(n_to_flush_valid), 64'd1);
      check("c1_end_count", 64'(n_to_flush), 64'd2);
      check("c1_drain_busy", 64'(busy), 64'd1);
      chk_ar("c1_drain_hold", 64'h1080);
      step();
      check("c1_strobe_single", 64'(n_to_flush_valid), 64'd0);
      ar_ready = 1'b1;
      step();
      chk_idle("c1_back_idle");

      // Mispredict with three speculative reads outstanding; stray head request ignored
      start_chain(64'h2000);
      step();
      chk_ar("m1_ar0", 64'h2000);
      head_addr  = 64'h7770;
      head_valid = 1'b1;
      step();
      step();
      step();
      step();
      check("m1_full_stop", 64'(ar_valid), 64'd0);
      check("m1_head_blocked", 64'(head_ready), 64'd0);
      pulse_done(64'h8000);
      check("m1_strobe", 64'(n_to_flush_valid), 64'd1);
      check("m1_count", 64'(n_to_flush), 64'd3);
      step();
      chk_ar("m1_redirect", 64'h8000);
      head_valid = 1'b0;
      do_reset();

      // Mispredict while 0x2040 is presented but not yet accepted
      ar_ready = 1'b1;
      start_chain(64'h2000);
      step();
      step();
      step();
      chk_ar("m2_presented", 64'h2040);
      ar_ready = 1'b0;
      pulse_done(64'h9000);
      check("m2_strobe", 64'(n_to_flush_valid), 64'd1);
      check("m2_count", 64'(n_to_flush), 64'd2);
      chk_ar("m2_stable0", 64'h2040);
      step();
      chk_ar("m2_stable1", 64'h2040);
      ar_ready = 1'b1;
      step();
      chk_ar("m2_redirect", 64'h9000);
      step();
      chk_ar("m2_next", 64'h9020);
      ar_ready = 1'b0;
      pulse_done(64'h9020);
      check("m2_not_pushed", 64'(n_to_flush_valid), 64'd0);
      do_reset();

      // Handshake of 0x3020 in the same cycle as a matching decode
      ar_ready = 1'b1;
      start_chain(64'h3000);
      step();
      step();
      chk_ar("s1_presented", 64'h3020);
      pulse_done(64'h3020);
      check("s1_match_nostrobe", 64'(n_to_flush_valid), 64'd0);
      chk_ar("s1_next", 64'h3040);
      ar_ready = 1'b0;
      pulse_done(ONES);
      check("s1_end_strobe", 64'(n_to_flush_valid), 64'd1);
      check("s1_end_count", 64'(n_to_flush), 64'd1);
      ar_ready = 1'b1;
      step();
      chk_idle("s1_back_idle");

      // Single-descriptor chain ending before the speculative AR is accepted
      start_chain(64'h4000);
      step();
      step();
      chk_ar("e1_presented", 64'h4020);
      ar_ready = 1'b0;
      pulse_done(ONES);
      check("e1_strobe", 64'(n_to_flush_valid), 64'd1);
      check("e1_count", 64'(n_to_flush), 64'd1);
      check("e1_drain_head_ready", 64'(head_ready), 64'd0);
      chk_ar("e1_drain_hold", 64'h4020);
      ar_ready = 1'b1;
      step();
      chk_idle("e1_back_idle");

      // Asynchronous reset with three descriptors outstanding
      start_chain(64'h6000);
      step();
      step();
      step();
      step();
      chk_ar("r1_presented", 64'h6060);
      #2;
      rst_ni = 1'b0;
      #1;
      check("r1_arvalid", 64'(ar_valid), 64'd0);
      check("r1_araddr", ar_addr, 64'd0);
      check("r1_nflush", 64'(n_to_flush), 64'd0);
      check("r1_head_ready", 64'(head_ready), 64'd1);
      check("r1_busy", 64'(busy), 64'd0);
      step();
      rst_ni = 1'b1;
      start_chain(64'h6100);
      check("r1_accepted", 64'(busy), 64'd1);
      step();
      chk_ar("r1_first_ar", 64'h6100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
